// File: rtl/comp_arbiter_if.sv
// Bundle between the two compare requesters, the shared comparator
// and the arbiter that sits in the middle.
interface comp_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [OPW-1:0]   req0_op;
    logic             req0_ready;
    logic             req0_done;
    logic             req0_result;

    logic             req1_valid;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [OPW-1:0]   req1_op;
    logic             req1_ready;
    logic             req1_done;
    logic             req1_result;

    logic [WIDTH-1:0] comp_a;
    logic [WIDTH-1:0] comp_b;
    logic [OPW-1:0]   comp_op;
    logic             comp_compout;

    logic             busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready, req0_done, req0_result,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready, req1_done, req1_result,
        output comp_a, comp_b, comp_op,
        input  comp_compout,
        output busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready, req0_done, req0_result,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready, req1_done, req1_result,
        input  comp_a, comp_b, comp_op,
        output comp_compout,
        input  busy
    );
endinterface

// File: rtl/comp_arbiter.sv
// Round-robin arbiter sharing one comparator between the branch
// unit (req0) and the set-on-compare path (req1).
module comp_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
) (
    input logic           clock,
    input logic           reset,
    comp_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] comp_a_q, comp_a_d;
    logic [WIDTH-1:0] comp_b_q, comp_b_d;
    logic [OPW-1:0]   comp_op_q, comp_op_d;
    logic             res0_q, res0_d;
    logic             res1_q, res1_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;

    logic             grant0;
    logic             grant1;
    logic             idle;
    logic             sample;

    // Grant selection and next-state / datapath computation.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        comp_a_d     = comp_a_q;
        comp_b_d     = comp_b_q;
        comp_op_d    = comp_op_q;
        res0_d       = res0_q;
        res1_d       = res1_q;
        done0_d      = 1'b0;
        done1_d      = 1'b0;

        idle   = (state_q == IDLE) && !reset;
        grant0 = bus.req0_valid && (!bus.req1_valid || last_grant_q);
        grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
        // Unused opcodes 110/111 never report true.
        sample = (comp_op_q > OPW'(5)) ? 1'b0 : bus.comp_compout;

        unique case (state_q)
            IDLE: begin
                if (grant0) begin
                    comp_a_d  = bus.req0_a;
                    comp_b_d  = bus.req0_b;
                    comp_op_d = bus.req0_op;
                    owner_d   = 1'b0;
                    state_d   = EVAL;
                end else if (grant1) begin
                    comp_a_d  = bus.req1_a;
                    comp_b_d  = bus.req1_b;
                    comp_op_d = bus.req1_op;
                    owner_d   = 1'b1;
                    state_d   = EVAL;
                end
            end
            EVAL: begin
                if (owner_q) begin
                    res1_d  = sample;
                    done1_d = 1'b1;
                end else begin
                    res0_d  = sample;
                    done0_d = 1'b1;
                end
                last_grant_d = owner_q;
                state_d      = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            comp_a_q     <= '0;
            comp_b_q     <= '0;
            comp_op_q    <= '0;
            res0_q       <= 1'b0;
            res1_q       <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            comp_a_q     <= comp_a_d;
            comp_b_q     <= comp_b_d;
            comp_op_q    <= comp_op_d;
            res0_q       <= res0_d;
            res1_q       <= res1_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
        end
    end

    assign bus.req0_ready  = grant0 && idle;
    assign bus.req1_ready  = grant1 && idle;
    assign bus.req0_done   = done0_q;
    assign bus.req1_done   = done1_q;
    assign bus.req0_result = res0_q;
    assign bus.req1_result = res1_q;
    assign bus.comp_a      = comp_a_q;
    assign bus.comp_b      = comp_b_q;
    assign bus.comp_op     = comp_op_q;
    assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_comp_arbiter.sv
// Directed bench for comp_arbiter: opcode table, contention,
// operand isolation and reset corner cases.
module tb_comp_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int checks = 0;
    int errors = 0;

    logic res_exp [2];

    comp_arbiter_if #(.WIDTH(32), .OPW(3)) bif ();

    comp_arbiter #(.WIDTH(32), .OPW(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bif.slave)
    );

    always #5 clock = ~clock;

    // Reference comparator: unused opcodes answer 1 on purpose.
    always_comb begin
        bif.comp_compout = 1'b1;
        case (bif.comp_op)
            3'd0: bif.comp_compout = (bif.comp_a == bif.comp_b);
            3'd1: bif.comp_compout = (bif.comp_a >= bif.comp_b);
            3'd2: bif.comp_compout = (bif.comp_a <= bif.comp_b);
            3'd3: bif.comp_compout = (bif.comp_a >  bif.comp_b);
            3'd4: bif.comp_compout = (bif.comp_a <  bif.comp_b);
            3'd5: bif.comp_compout = (bif.comp_a != bif.comp_b);
            default: bif.comp_compout = 1'b1;
        endcase
    end

    typedef struct {
        bit          which;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic        exp;
    } vec_t;

    vec_t vecs [8];

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b want %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkw(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit which, input logic v,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op);
        if (which) begin
            bif.req1_valid = v;
            bif.req1_a     = a;
            bif.req1_b     = b;
            bif.req1_op    = op;
        end else begin
            bif.req0_valid = v;
            bif.req0_a     = a;
            bif.req0_b     = b;
            bif.req0_op    = op;
        end
    endtask

    function automatic logic rdy(input bit which);
        return which ? bif.req1_ready : bif.req0_ready;
    endfunction

    function automatic logic dn(input bit which);
        return which ? bif.req1_done : bif.req0_done;
    endfunction

    // One full transaction; optionally scribble on req0_a after capture.
    task automatic issue(input bit which, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] op,
                         input logic exp, input bit isolate);
        bit seen;
        @(negedge clock);
        drive(which, 1'b1, a, b, op);
        #1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (rdy(which)) begin
                seen = 1'b1;
                break;
            end
            @(negedge clock);
            #1;
        end
        chk1("ready_seen", seen, 1'b1);
        if (!seen) begin
            drive(which, 1'b0, a, b, op);
            return;
        end
        chk1("other_ready", rdy(!which), 1'b0);
        @(negedge clock);
        drive(which, 1'b0, isolate ? 32'd0 : a, b, op);
        chk1("eval_busy", bif.busy, 1'b1);
        chkw("eval_comp_a", bif.comp_a, a);
        chkw("eval_comp_b", bif.comp_b, b);
        chkw("eval_comp_op", 32'(bif.comp_op), 32'(op));
        chk1("eval_done0", bif.req0_done, 1'b0);
        chk1("eval_done1", bif.req1_done, 1'b0);
        @(negedge clock);
        res_exp[which] = exp;
        chk1("done_own", dn(which), 1'b1);
        chk1("done_other", dn(!which), 1'b0);
        chk1("result0", bif.req0_result, res_exp[0]);
        chk1("result1", bif.req1_result, res_exp[1]);
        @(negedge clock);
        chk1("idle_busy", bif.busy, 1'b0);
        chk1("idle_done", dn(which), 1'b0);
        chk1("idle_result", which ? bif.req1_result : bif.req0_result,
             res_exp[which]);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        res_exp[0] = 1'b0;
        res_exp[1] = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'd128, 32'd128, 3'd0, 1'b1};
        vecs[1] = '{1'b1, 32'd128, 32'd16,  3'd1, 1'b1};
        vecs[2] = '{1'b1, 32'd1,   32'd128, 3'd1, 1'b0};
        vecs[3] = '{1'b1, 32'd16,  32'd16,  3'd2, 1'b1};
        vecs[4] = '{1'b1, 32'd128, 32'd128, 3'd3, 1'b0};
        vecs[5] = '{1'b1, 32'd8,   32'd16,  3'd4, 1'b1};
        vecs[6] = '{1'b1, 32'd1,   32'd0,   3'd5, 1'b1};
        vecs[7] = '{1'b1, 32'd5,   32'd5,   3'd6, 1'b0};

        res_exp[0] = 1'b0;
        res_exp[1] = 1'b0;
        drive(1'b0, 1'b1, 32'd7, 32'd9, 3'd0);
        drive(1'b1, 1'b0, 32'd0, 32'd0, 3'd0);

        // Reset held two cycles with req0 asking: everything stays quiet.
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            chk1("rst_ready0", bif.req0_ready, 1'b0);
            chk1("rst_ready1", bif.req1_ready, 1'b0);
            chk1("rst_done0", bif.req0_done, 1'b0);
            chk1("rst_done1", bif.req1_done, 1'b0);
            chk1("rst_res0", bif.req0_result, 1'b0);
            chk1("rst_res1", bif.req1_result, 1'b0);
            chk1("rst_busy", bif.busy, 1'b0);
            chkw("rst_comp_a", bif.comp_a, 32'd0);
            chkw("rst_comp_b", bif.comp_b, 32'd0);
            chkw("rst_comp_op", 32'(bif.comp_op), 32'd0);
        end
        reset = 1'b0;
        #1;
        chk1("first_idle_ready0", bif.req0_ready, 1'b1);
        drive(1'b0, 1'b0, 32'd7, 32'd9, 3'd0);
        @(negedge clock);
        chk1("dropped_busy", bif.busy, 1'b0);
        chkw("dropped_comp_a", bif.comp_a, 32'd0);

        for (int i = 0; i < 8; i++)
            issue(vecs[i].which, vecs[i].a, vecs[i].b, vecs[i].op,
                  vecs[i].exp, 1'b0);

        chk1("hold_res0", bif.req0_result, 1'b1);
        chkw("hold_comp_a", bif.comp_a, 32'd5);

        // Operand changed after capture must not matter.
        issue(1'b0, 32'd128, 32'd128, 3'd0, 1'b1, 1'b1);
        issue(1'b0, 32'd1, 32'd2, 3'd0, 1'b0, 1'b0);

        // Reset during EVAL: no done pulse, clean restart.
        @(negedge clock);
        drive(1'b1, 1'b1, 32'd1, 32'd128, 3'd4);
        #1;
        chk1("mid_ready1", bif.req1_ready, 1'b1);
        @(negedge clock);
        drive(1'b1, 1'b0, 32'd1, 32'd128, 3'd4);
        reset = 1'b1;
        chk1("mid_busy_eval", bif.busy, 1'b1);
        @(negedge clock);
        chk1("mid_busy_after", bif.busy, 1'b0);
        chk1("mid_done1", bif.req1_done, 1'b0);
        chk1("mid_res0_cleared", bif.req0_result, 1'b0);
        reset = 1'b0;
        res_exp[0] = 1'b0;
        res_exp[1] = 1'b0;
        @(negedge clock);
        chk1("mid_done1_late", bif.req1_done, 1'b0);
        chk1("mid_res1", bif.req1_result, 1'b0);
        issue(1'b1, 32'd8, 32'd16, 3'd4, 1'b1, 1'b0);

        // Contention from reset: grants alternate 0,1,0.
        do_reset();
        drive(1'b0, 1'b1, 32'd256, 32'd128, 3'd3);
        drive(1'b1, 1'b1, 32'd256, 32'd256, 3'd4);
        #1;
        for (int i = 0; i < 9; i++) begin
            chk1("ct_ready0", bif.req0_ready,
                 (i == 0) || (i == 6));
            chk1("ct_ready1", bif.req1_ready, i == 3);
            chk1("ct_done0", bif.req0_done, (i == 2) || (i == 8));
            chk1("ct_done1", bif.req1_done, i == 5);
            chk1("ct_busy", bif.busy, (i % 3) != 0);
            if (i == 1 || i == 7)
                chkw("ct_comp_b0", bif.comp_b, 32'd128);
            if (i == 4)
                chkw("ct_comp_b1", bif.comp_b, 32'd256);
            chk1("ct_res0", bif.req0_result, i >= 2);
            chk1("ct_res1", bif.req1_result, 1'b0);
            @(negedge clock);
            #1;
        end
        drive(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        drive(1'b1, 1'b0, 32'd0, 32'd0, 3'd0);
        @(negedge clock);
        chk1("ct_end_busy", bif.busy, 1'b0);
        chk1("ct_end_res0", bif.req0_result, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
